// File: rtl/scan_pkg.sv
// Shared constants and types for the scan frame controller.
// Optional WAIT timeout is enabled by defining SCAN_TIMEOUT_EN.
package scan_pkg;

  localparam int FRAME_W = 45;
  localparam int RESP_W  = 34;
  localparam int CNT_W   = 6;

  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [1:0] CMD_RD = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;
  localparam logic [1:0] ST_OVERRUN = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ISSUE,
    S_WAIT
  } state_e;

  function automatic logic is_xfer(input logic [1:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/scan_timeout_ctr.sv
// WAIT-state cycle counter; expire marks the LIMIT-th enabled cycle.
// Only instantiated when SCAN_TIMEOUT_EN is defined.
module scan_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expire = en && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_frame_ctrl.sv
// Serial scan frame to mem/reg transaction bridge.
// Define SCAN_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
module scan_frame_ctrl
  import scan_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        scan_in,
  output logic        scan_out,
  output logic        scan_busy,
  output logic        scan_ren,
  output logic        scan_wen,
  output logic [10:0] scan_addr,
  output logic [31:0] scan_wdata,
  input  logic [31:0] scan_rdata,
  input  logic        scan_ready
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-2:0] frame;
  logic [RESP_W-1:0]  resp;
  logic               ovr;
  logic               is_rd;
  logic [FRAME_W-1:0] frame_nx;
  logic [1:0]         cmd_nx;
  logic               tmo;
  logic [1:0]         done_st;

  assign frame_nx = {frame, scan_in};
  assign cmd_nx   = frame_nx[FRAME_W-1 -: 2];
  assign scan_out = resp[RESP_W-1];
  assign done_st  = (ovr || scan_en) ? ST_OVERRUN : ST_OK;

`ifdef SCAN_TIMEOUT_EN
  scan_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == S_ISSUE),
    .en     (state == S_WAIT),
    .expire (tmo)
  );
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      frame      <= '0;
      resp       <= '0;
      ovr        <= 1'b0;
      is_rd      <= 1'b0;
      scan_busy  <= 1'b0;
      scan_ren   <= 1'b0;
      scan_wen   <= 1'b0;
      scan_addr  <= '0;
      scan_wdata <= '0;
    end else begin
      scan_ren <= 1'b0;
      scan_wen <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (scan_en) begin
            state <= S_SHIFT;
            frame <= {{(FRAME_W-2){1'b0}}, scan_in};
            cnt   <= CNT_W'(1);
            resp  <= resp << 1;
          end
        end
        S_SHIFT: begin
          if (scan_en) begin
            frame <= frame_nx[FRAME_W-2:0];
            resp  <= resp << 1;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_W'(FRAME_W - 1)) begin
              cnt <= '0;
              if (is_xfer(cmd_nx)) begin
                state      <= S_ISSUE;
                scan_busy  <= 1'b1;
                scan_addr  <= frame_nx[42:32];
                scan_wdata <= frame_nx[31:0];
                scan_wen   <= (cmd_nx == CMD_WR);
                scan_ren   <= (cmd_nx == CMD_RD);
                is_rd      <= (cmd_nx == CMD_RD);
              end else begin
                state <= S_IDLE;
                resp  <= {ST_ABORT, 32'h0};
              end
            end
          end else begin
            state <= S_IDLE;
            cnt   <= '0;
            resp  <= {ST_ABORT, 32'h0};
          end
        end
        S_ISSUE, S_WAIT: begin
          if (scan_en) ovr <= 1'b1;
          if (scan_ready) begin
            state     <= S_IDLE;
            scan_busy <= 1'b0;
            ovr       <= 1'b0;
            resp      <= {done_st, is_rd ? scan_rdata : 32'h0};
          end else if (tmo) begin
            state     <= S_IDLE;
            scan_busy <= 1'b0;
            ovr       <= 1'b0;
            resp      <= {ST_TIMEOUT, 32'h0};
          end else begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_frame_ctrl.sv
// Randomized bench for scan_frame_ctrl against a frame-level model.
// Define SCAN_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_scan_frame_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        scan_in = 1'b0;
  logic        scan_ready = 1'b0;
  logic [31:0] scan_rdata = '0;
  logic        scan_out;
  logic        scan_busy;
  logic        scan_ren;
  logic        scan_wen;
  logic [10:0] scan_addr;
  logic [31:0] scan_wdata;

  scan_frame_ctrl #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .scan_busy  (scan_busy),
    .scan_ren   (scan_ren),
    .scan_wen   (scan_wen),
    .scan_addr  (scan_addr),
    .scan_wdata (scan_wdata),
    .scan_rdata (scan_rdata),
    .scan_ready (scan_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int both_cnt = 0;
  logic [33:0] exp_resp = '0;

  always @(negedge clk) begin
    if (scan_wen) wen_cnt++;
    if (scan_ren) ren_cnt++;
    if (scan_wen && scan_ren) both_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Shift one frame (possibly truncated) and compare the unloaded prefix.
  task automatic send(input logic [1:0] cmd, input logic [10:0] addr,
                      input logic [31:0] data, input int nbits);
    logic [44:0] f;
    logic [33:0] got;
    int n;
    f = {cmd, addr, data};
    got = '0;
    n = (nbits < 34) ? nbits : 34;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      scan_en = 1'b1;
      scan_in = f[44-i];
      if (i < 34) got = {got[32:0], scan_out};
    end
    check("unload", 64'(got), 64'(exp_resp >> (34 - n)));
  endtask

  task automatic txn(input logic [1:0] cmd, input logic [10:0] addr,
                     input logic [31:0] data, input int nbits,
                     input int delay, input int ov,
                     input logic [31:0] rdata);
    int w0, r0;
    bit xfer;
    w0 = wen_cnt;
    r0 = ren_cnt;
    xfer = (cmd == 2'b01) || (cmd == 2'b10);
    send(cmd, addr, data, nbits);
    if (nbits < 45 || !xfer) begin
      @(negedge clk);
      scan_en = 1'b0;
      @(negedge clk);
      check("idle_busy", 64'(scan_busy), 64'd0);
      check("no_strobe", 64'(wen_cnt - w0 + ren_cnt - r0), 64'd0);
      exp_resp = {2'b10, 32'h0};
      return;
    end
    for (int j = 0; j <= delay; j++) begin
      @(negedge clk);
      scan_en = (j < ov);
      scan_in = 1'($urandom);
      scan_ready = (j == delay);
      scan_rdata = (j == delay) ? rdata : $urandom;
      if (j == 0) begin
        check("busy_issue", 64'(scan_busy), 64'd1);
        check("addr", 64'(scan_addr), 64'(addr));
        check("wdata", 64'(scan_wdata), 64'(data));
      end
    end
    @(negedge clk);
    scan_en = 1'b0;
    scan_ready = 1'b0;
    check("busy_done", 64'(scan_busy), 64'd0);
    check("wen_pulses", 64'(wen_cnt - w0), 64'(cmd == 2'b01));
    check("ren_pulses", 64'(ren_cnt - r0), 64'(cmd == 2'b10));
    check("addr_hold", 64'(scan_addr), 64'(addr));
    exp_resp = {(ov > 0) ? 2'b11 : 2'b00,
                (cmd == 2'b10) ? rdata : 32'h0};
  endtask

  task automatic stall_test(input logic [31:0] r);
    int n;
    send(2'b10, 11'h123, 32'h0, 45);
    @(negedge clk);
    scan_en = 1'b0;
    scan_ready = 1'b0;
    check("stall_busy", 64'(scan_busy), 64'd1);
    n = 0;
    while (scan_busy && n < 40) begin
      @(negedge clk);
      if (scan_busy) n++;
    end
`ifdef SCAN_TIMEOUT_EN
    check("tmo_cycles", 64'(n), 64'(TMO));
    check("tmo_busy", 64'(scan_busy), 64'd0);
    exp_resp = {2'b01, 32'h0};
`else
    check("hold_busy", 64'(scan_busy), 64'd1);
    scan_ready = 1'b1;
    scan_rdata = r;
    @(negedge clk);
    scan_ready = 1'b0;
    check("hold_done", 64'(scan_busy), 64'd0);
    exp_resp = {2'b00, r};
`endif
  endtask

  task automatic reset_test();
    send(2'b01, 11'h7ff, 32'h1234_5678, 45);
    @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_outs",
          64'({scan_wen, scan_ren, scan_busy, scan_out,
               scan_addr, scan_wdata}), 64'd0);
    @(negedge clk);
    check("rst_held", 64'({scan_busy, scan_wen}), 64'd0);
    rst_n = 1'b1;
    exp_resp = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state",
          64'({scan_wen, scan_ren, scan_busy, scan_out,
               scan_addr, scan_wdata}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    txn(2'b01, 11'h005, 32'hDEAD_BEEF, 45, 1, 0, 32'h0);
    txn(2'b10, 11'h600, 32'h0, 45, 0, 0, 32'h0000_0003);
    txn(2'b01, 11'h0aa, 32'h5555_aaaa, 20, 0, 0, 32'h0);
    txn(2'b00, 11'h011, 32'hffff_0000, 45, 0, 0, 32'h0);
    txn(2'b10, 11'h3c3, 32'h0, 45, 14, 15, 32'hcafe_f00d);
    stall_test(32'h0bad_c0de);
    txn(2'b11, 11'h001, 32'h1, 45, 0, 0, 32'h0);
    reset_test();
    txn(2'b10, 11'h402, 32'h0, 45, 2, 0, 32'h8765_4321);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] c;
      int nb, dl, ov;
      c = 2'($urandom_range(0, 3));
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 44) : 45;
      dl = $urandom_range(0, 6);
      ov = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dl + 1) : 0;
      txn(c, 11'($urandom), $urandom, nb, dl, ov, $urandom);
    end
    txn(2'b00, 11'h0, 32'h0, 45, 0, 0, 32'h0);

    check("never_both", 64'(both_cnt), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
